// File: rtl/fp_pkg.sv
// Shared definitions for the digit-serial add/sub/compare block: FSM state
// encoding and the width helper used for address and counter sizing.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int unsigned CLOG2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/single_port_mem.sv
// Single-port synchronous RAM with registered read data.
module single_port_mem #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/fp_addsub_cmp.sv
// Digit-serial multi-word add/subtract with carry chain and an optional
// unsigned compare against a ROM constant (built when FP_ADDSUB_CONST_CMP_EN is defined).
module fp_addsub_cmp
  import fp_pkg::*;
#(
  parameter int unsigned RADIX      = 32,
  parameter int unsigned DIGITS     = 14,
  parameter string       FILE_CONST = "zero.mem"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic             carry_in,
  input  logic             digit_in_valid,
  input  logic [RADIX-1:0] digit_a,
  input  logic [RADIX-1:0] digit_b,
  output logic             digit_out_valid,
  output logic [RADIX-1:0] digit_res,
  output logic             carry_out,
  output logic             res_neg,
  output logic             res_ge_const,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W  = CLOG2(DIGITS + 1);
  localparam int unsigned ADDR_W = (DIGITS > 1) ? CLOG2(DIGITS) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sub_q;
  logic             carry_q;
  logic             accept;
  logic             last_acc;
  logic             done_nxt;
  logic [RADIX-1:0] b_eff;
  logic [RADIX:0]   sum;

  // start wins over a coincident digit, so the digit is never accepted
  assign accept   = (state == RUN) && digit_in_valid && !start && (cnt < CNT_W'(DIGITS));
  assign last_acc = accept && (cnt == CNT_W'(DIGITS - 1));
  assign busy      = (state != IDLE);
  assign carry_out = carry_q;

  always_comb begin
    b_eff = sub_q ? ~digit_b : digit_b;
    sum   = {1'b0, digit_a} + {1'b0, b_eff} + {{RADIX{1'b0}}, carry_q};
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        RUN:   if (last_acc) state_nxt = FLUSH;
        FLUSH: begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      sub_q           <= 1'b0;
      carry_q         <= 1'b0;
      digit_res       <= '0;
      digit_out_valid <= 1'b0;
      done            <= 1'b0;
      res_neg         <= 1'b0;
    end else begin
      state           <= state_nxt;
      done            <= done_nxt;
      digit_out_valid <= accept;
      if (start) begin
        cnt     <= '0;
        sub_q   <= op_sub;
        carry_q <= carry_in;
        res_neg <= 1'b0;
      end else if (accept) begin
        cnt       <= cnt + CNT_W'(1);
        carry_q   <= sum[RADIX];
        digit_res <= sum[RADIX-1:0];
      end
      if (done_nxt) res_neg <= digit_res[RADIX-1];
    end
  end

`ifdef FP_ADDSUB_CONST_CMP_EN
  logic [ADDR_W-1:0] addr;
  logic [RADIX-1:0]  const_digit;
  logic              borrow;
  logic              borrow_nxt;
  logic [RADIX:0]    sub_rhs;

  // Read address tracks the digit being accepted, so the registered read
  // data lines up with digit_res in the following cycle.
  single_port_mem #(
    .WIDTH     (RADIX),
    .DEPTH     (DIGITS),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (FILE_CONST)
  ) u_const (
    .clk   (clk),
    .we    (1'b0),
    .addr  (addr),
    .wdata ('0),
    .rdata (const_digit)
  );

  always_comb begin
    sub_rhs    = {1'b0, const_digit} + {{RADIX{1'b0}}, borrow};
    borrow_nxt = digit_out_valid ? ({1'b0, digit_res} < sub_rhs) : borrow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      borrow       <= 1'b0;
      res_ge_const <= 1'b0;
    end else if (start) begin
      addr         <= '0;
      borrow       <= 1'b0;
      res_ge_const <= 1'b0;
    end else begin
      borrow <= borrow_nxt;
      if (done_nxt) begin
        res_ge_const <= ~borrow_nxt;
        addr         <= '0;
      end else if (accept && (addr != ADDR_W'(DIGITS - 1))) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end
`else
  assign res_ge_const = 1'b0;
`endif

endmodule

// File: tb/tb_fp_addsub_cmp.sv
// Directed self-checking bench for fp_addsub_cmp (RADIX=8, DIGITS=4, constant 0x00000100).
module tb_fp_addsub_cmp;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       op_sub;
  logic       carry_in;
  logic       digit_in_valid;
  logic [7:0] digit_a;
  logic [7:0] digit_b;
  logic       digit_out_valid;
  logic [7:0] digit_res;
  logic       carry_out;
  logic       res_neg;
  logic       res_ge_const;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  fp_addsub_cmp #(
    .RADIX      (8),
    .DIGITS     (4),
    .FILE_CONST ("")
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op_sub          (op_sub),
    .carry_in        (carry_in),
    .digit_in_valid  (digit_in_valid),
    .digit_a         (digit_a),
    .digit_b         (digit_b),
    .digit_out_valid (digit_out_valid),
    .digit_res       (digit_res),
    .carry_out       (carry_out),
    .res_neg         (res_neg),
    .res_ge_const    (res_ge_const),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/res"},   32'(digit_res), 32'h0);
    chk({tag, "/dov"},   32'(digit_out_valid), 32'h0);
    chk({tag, "/cout"},  32'(carry_out), 32'h0);
    chk({tag, "/neg"},   32'(res_neg), 32'h0);
    chk({tag, "/ge"},    32'(res_ge_const), 32'h0);
    chk({tag, "/busy"},  32'(busy), 32'h0);
    chk({tag, "/done"},  32'(done), 32'h0);
  endtask

  // Called at a negedge; drives one digit and checks it one cycle later.
  task automatic send_digit(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_res);
    digit_in_valid = 1'b1;
    digit_a = a;
    digit_b = b;
    @(negedge clk);
    digit_in_valid = 1'b0;
    chk({tag, "/dov"}, 32'(digit_out_valid), 32'h1);
    chk({tag, "/res"}, 32'(digit_res), 32'(exp_res));
  endtask

  task automatic start_op(input logic sub, input logic cin);
    start = 1'b1;
    op_sub = sub;
    carry_in = cin;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin, input logic [31:0] exp_res,
                        input logic exp_c, input logic exp_neg, input logic exp_ge,
                        input bit gapped, input bit abort);
    int   done_before;
    logic ge_req;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] er;
`ifdef FP_ADDSUB_CONST_CMP_EN
    ge_req = exp_ge;
`else
    ge_req = 1'b0;
`endif
    done_before = done_cnt;
    if (abort) begin
      start_op(1'b0, 1'b0);
      send_digit({name, "/pre0"}, 8'hFF, 8'h01, 8'h00);
      send_digit({name, "/pre1"}, 8'h00, 8'h00, 8'h01);
    end
    // a digit presented together with start must be dropped
    start = 1'b1;
    op_sub = sub;
    carry_in = cin;
    digit_in_valid = abort;
    digit_a = 8'hAA;
    digit_b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    digit_in_valid = 1'b0;
    chk({name, "/dov0"}, 32'(digit_out_valid), 32'h0);
    chk({name, "/busy"}, 32'(busy), 32'h1);
    chk({name, "/cin"},  32'(carry_out), 32'(cin));
    chk({name, "/ge0"},  32'(res_ge_const), 32'h0);
    for (int unsigned k = 0; k < 4; k++) begin
      ea = a[8*k +: 8];
      eb = b[8*k +: 8];
      er = exp_res[8*k +: 8];
      send_digit($sformatf("%s/d%0d", name, k), ea, eb, er);
      if (gapped && k < 3) begin
        @(negedge clk);
        chk($sformatf("%s/gap%0d", name, k), 32'(digit_out_valid), 32'h0);
      end
    end
    chk({name, "/early_done"}, 32'(done), 32'h0);
    chk({name, "/flush_busy"}, 32'(busy), 32'h1);
    if (gapped) begin
      digit_in_valid = 1'b1;
      digit_a = 8'hFF;
      digit_b = 8'hFF;
    end
    @(negedge clk);
    digit_in_valid = 1'b0;
    chk({name, "/done"},  32'(done), 32'h1);
    chk({name, "/dov5"},  32'(digit_out_valid), 32'h0);
    chk({name, "/idle"},  32'(busy), 32'h0);
    chk({name, "/cout"},  32'(carry_out), 32'(exp_c));
    chk({name, "/neg"},   32'(res_neg), 32'(exp_neg));
    chk({name, "/ge"},    32'(res_ge_const), 32'(ge_req));
    @(negedge clk);
    chk({name, "/done_pulse"}, 32'(done), 32'h0);
    chk({name, "/ge_hold"},    32'(res_ge_const), 32'(ge_req));
    chk({name, "/done_cnt"},   32'(done_cnt - done_before), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op_sub = 1'b0;
    carry_in = 1'b0;
    digit_in_valid = 1'b0;
    digit_a = '0;
    digit_b = '0;
`ifdef FP_ADDSUB_CONST_CMP_EN
    dut.u_const.mem[0] <= 8'h00;
    dut.u_const.mem[1] <= 8'h01;
    dut.u_const.mem[2] <= 8'h00;
    dut.u_const.mem[3] <= 8'h00;
`endif
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op("add",     32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub",     32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("bnd_ff",  32'h00000100, 32'h00000001, 1'b1, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("bnd_100", 32'h00000200, 32'h00000100, 1'b1, 1'b1, 32'h00000100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("gapped",  32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("restart", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    begin : rst_mid_op
      int done_before;
      done_before = done_cnt;
      start_op(1'b0, 1'b0);
      send_digit("rstop/d0", 8'hFF, 8'h01, 8'h00);
      send_digit("rstop/d1", 8'hFF, 8'h01, 8'h01);
      chk("rstop/cout_pre", 32'(carry_out), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("rstop");
      repeat (6) @(negedge clk);
      chk("rstop/no_done", 32'(done_cnt - done_before), 32'h0);
      chk("rstop/busy", 32'(busy), 32'h0);
    end

    run_op("post_rst", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_cmp.md
FP_ADDSUB_CMP -- requirements
Module: fp_addsub_cmp

Interface
REQ-001 Parameter RADIX, 32, digit width in bits.
REQ-002 Parameter DIGITS, 14, number of digits per operand (LSB digit first).
REQ-003 Parameter FILE_CONST, "zero.mem", memory init file holding the comparison constant, LSB digit at address 0.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; begins an operation and samples op_sub and carry_in.
REQ-007 op_sub  in  1  1 = A + ~B + carry, 0 = A + B + carry; sampled at start.
REQ-008 carry_in  in  1  initial carry; sampled at start.
REQ-009 digit_in_valid  in  1  qualifies digit_a/digit_b; may be non-contiguous.
REQ-010 digit_a, digit_b  in  RADIX  operand digits.
REQ-011 digit_out_valid  out  1  qualifies digit_res.
REQ-012 digit_res  out  RADIX  result digit.
REQ-013 carry_out  out  1  running carry after the last accepted digit.
REQ-014 res_neg  out  1  MSB of the final result digit.
REQ-015 res_ge_const  out  1  full result, unsigned, >= constant.
REQ-016 busy  out  1  high from the cycle after start until done.
REQ-017 done  out  1  one-cycle pulse when all flags are valid.

Function
REQ-018 FSM states: IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH when the DIGITS-th digit_out_valid issues; FLUSH->IDLE after one cycle with done=1.
REQ-019 Each digit: {c, digit_res} = digit_a + (op_sub ? ~digit_b : digit_b) + c; digit_res and digit_out_valid registered, latency 1 cycle after digit_in_valid.
REQ-020 Carry register loaded with carry_in at start and updated only on accepted digits; carry_out mirrors it.
REQ-021 Digit counter counts accepted digits; digit_in_valid ignored in IDLE, in FLUSH, and once DIGITS digits have been accepted.
REQ-022 Constant memory read address advances on each accepted digit, saturates at DIGITS-1, and clears on start and on done; synchronous read aligns the constant digit with digit_res.
REQ-023 Compare chain: on each digit_out_valid, borrow <= (digit_res - const_digit - borrow) underflows; borrow cleared at start.
REQ-024 On done: res_ge_const = !borrow_final; res_neg = MSB of the last digit_res; both hold until the next start, which clears them to 0.
REQ-025 done asserts exactly 1 cycle after the last digit_out_valid.
REQ-026 start while busy aborts the current operation and restarts with the new op_sub/carry_in; no done is issued for the aborted operation.
REQ-027 start and digit_in_valid in the same cycle: the digit is ignored.

Reset
REQ-028 On rst all outputs go to 0, the FSM enters IDLE, and the counters, carry and borrow clear; rst mid-operation discards the operation with no done.

Configuration
REQ-029 Macro FP_ADDSUB_CONST_CMP_EN: when defined, the constant memory and compare chain are built.
REQ-030 Without FP_ADDSUB_CONST_CMP_EN, the constant memory and compare chain are not built; res_ge_const is tied to 0; all other behaviour and timing are unchanged.

Structure
REQ-031 Shared package fp_pkg holds the FSM state encoding and the CLOG2 width helper for address and counter widths.
REQ-032 The constant store is one instance of the existing single_port_mem (write disabled); no other sub-modules.

Verification (RADIX=8, DIGITS=4, constant 0x00000100)
REQ-033 Add: A=0x000000FF, B=0x00000001, op_sub=0, carry_in=0 -> digits 00,01,00,00; carry_out=0, res_ge_const=1, res_neg=0; done 1 cycle after the 4th digit.
REQ-034 Sub: A=0x00000005, B=0x00000007, op_sub=1, carry_in=1 -> 0xFFFFFFFE; res_neg=1, carry_out=0, res_ge_const=1.
REQ-035 Boundary: A-B = 0x000000FF -> res_ge_const=0; A-B = 0x00000100 -> res_ge_const=1.
REQ-036 Gapped digit_in_valid (idle cycles between digits) -> same results as REQ-033; extra 5th digit ignored.
REQ-037 start after 2 digits -> restart; exactly one done; rst after 2 digits -> all outputs 0, no done.
REQ-038 Build without FP_ADDSUB_CONST_CMP_EN, rerun REQ-033 -> identical digits and timing, res_ge_const=0.
